// File: rtl/gray_to_binary_sync.sv
// Gray-count receiver: synchronizes an async Gray count, decodes it to binary and
// reports each change as a one-cycle b_valid pulse with direction and step-error tracking.
module gray_to_binary_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] g,
  input  logic             clr_err,
  output logic [WIDTH-1:0] b,
  output logic             b_valid,
  output logic             dir,
  output logic             step_err,
  output logic [7:0]       err_cnt
);

  localparam int CW = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    LOAD  = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t                             state_q;
  logic [CW-1:0]                      cnt_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_q;
  logic [WIDTH-1:0]                   b_q;
  logic                               b_valid_q;
  logic                               dir_q;
  logic                               step_err_q;
  logic [7:0]                         err_cnt_q;

  logic [WIDTH-1:0] gs;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] delta_d;
  logic [7:0]       err_cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= g;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign gs = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin = bin ^ (gs >> i);
    end
  end

  assign delta_d     = bin - b_q;
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      b_q        <= '0;
      b_valid_q  <= 1'b0;
      dir_q      <= 1'b1;
      step_err_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      b_valid_q <= 1'b0;
      if (clr_err) begin
        step_err_q <= 1'b0;
        err_cnt_q  <= 8'd0;
      end
      case (state_q)
        FILL: begin
          if (cnt_q == CW'(SYNC_STAGES - 1)) begin
            state_q <= LOAD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        LOAD: begin
          b_q       <= bin;
          b_valid_q <= 1'b1;
          state_q   <= TRACK;
        end
        TRACK: begin
          if (delta_d != '0) begin
            b_q       <= bin;
            b_valid_q <= 1'b1;
            if (delta_d == WIDTH'(1)) begin
              dir_q <= 1'b1;
            end else if (delta_d == {WIDTH{1'b1}}) begin
              dir_q <= 1'b0;
            end else begin
              // An illegal step outranks a simultaneous clear.
              step_err_q <= 1'b1;
              err_cnt_q  <= clr_err ? 8'd1 : err_cnt_inc;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign b        = b_q;
  assign b_valid  = b_valid_q;
  assign dir      = dir_q;
  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gray_to_binary_sync.sv
// Directed bench for gray_to_binary_sync: reset/load, sweeps, wrap, illegal jumps,
// error clearing and asynchronous mid-run reset.
module tb_gray_to_binary_sync;

  logic       clk;
  logic       rst_n;
  logic [3:0] g;
  logic       clr_err;
  logic [3:0] b;
  logic       b_valid;
  logic       dir;
  logic       step_err;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  logic [3:0] cur_g;

  gray_to_binary_sync #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .g        (g),
    .clr_err  (clr_err),
    .b        (b),
    .b_valid  (b_valid),
    .dir      (dir),
    .step_err (step_err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Change g between edges and stop 1 time unit after the edge that publishes it.
  task automatic apply(input logic [3:0] v);
    @(negedge clk);
    g = v;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] v);
    g = v;
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    g = 4'b0111;
    clr_err = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++; if (b !== 4'd0) begin $display("FAIL reset_b got %0d exp 0", b); errors++; end
    checks++; if (b_valid !== 1'b0) begin $display("FAIL reset_b_valid got %b exp 0", b_valid); errors++; end
    checks++; if (dir !== 1'b1) begin $display("FAIL reset_dir got %b exp 1", dir); errors++; end
    checks++; if (step_err !== 1'b0) begin $display("FAIL reset_step_err got %b exp 0", step_err); errors++; end
    checks++; if (err_cnt !== 8'd0) begin $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); errors++; end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      checks++; if (b_valid !== 1'b0 || b !== 4'd0) begin
        $display("FAIL fill_edge%0d b=%0d b_valid=%b exp b=0 b_valid=0", i, b, b_valid); errors++;
      end
    end
    @(posedge clk); #1;
    checks++; if (b_valid !== 1'b1) begin $display("FAIL load_b_valid got %b exp 1", b_valid); errors++; end
    checks++; if (b !== 4'd5) begin $display("FAIL load_b got %0d exp 5", b); errors++; end
    checks++; if (step_err !== 1'b0) begin $display("FAIL load_step_err got %b exp 0", step_err); errors++; end
    @(posedge clk); #1;
    checks++; if (b_valid !== 1'b0) begin $display("FAIL load_pulse_width got %b exp 0", b_valid); errors++; end
  endtask

  task automatic test_up_sweep;
    logic [3:0] exp_b;
    do_reset(4'b0000);
    checks++; if (b !== 4'd0) begin $display("FAIL sweep_start_b got %0d exp 0", b); errors++; end
    for (int i = 1; i <= 16; i++) begin
      exp_b = 4'(i % 16);
      apply(exp_b ^ (exp_b >> 1));
      checks++; if (b !== exp_b || b_valid !== 1'b1) begin
        $display("FAIL up_sweep_%0d b=%0d b_valid=%b exp b=%0d b_valid=1", i, b, b_valid, exp_b); errors++;
      end
      checks++; if (dir !== 1'b1 || step_err !== 1'b0) begin
        $display("FAIL up_sweep_flags_%0d dir=%b step_err=%b exp dir=1 step_err=0", i, dir, step_err); errors++;
      end
      @(posedge clk); #1;
      checks++; if (b_valid !== 1'b0) begin $display("FAIL up_sweep_pulse_%0d got %b exp 0", i, b_valid); errors++; end
    end
  endtask

  task automatic test_down_wrap;
    apply(4'b1000);
    checks++; if (b !== 4'd15 || b_valid !== 1'b1) begin
      $display("FAIL down_wrap_b b=%0d b_valid=%b exp b=15 b_valid=1", b, b_valid); errors++;
    end
    checks++; if (dir !== 1'b0 || step_err !== 1'b0) begin
      $display("FAIL down_wrap_flags dir=%b step_err=%b exp dir=0 step_err=0", dir, step_err); errors++;
    end
    apply(4'b1001);
    checks++; if (b !== 4'd14 || dir !== 1'b0) begin
      $display("FAIL down_step b=%0d dir=%b exp b=14 dir=0", b, dir); errors++;
    end
  endtask

  task automatic test_illegal_jump;
    do_reset(4'b0000);
    cur_g = 4'b0011;
    apply(cur_g);
    checks++; if (b !== 4'd2 || b_valid !== 1'b1) begin
      $display("FAIL illegal_b b=%0d b_valid=%b exp b=2 b_valid=1", b, b_valid); errors++;
    end
    checks++; if (step_err !== 1'b1 || err_cnt !== 8'd1) begin
      $display("FAIL illegal_err step_err=%b err_cnt=%0d exp 1 and 1", step_err, err_cnt); errors++;
    end
    checks++; if (dir !== 1'b1) begin $display("FAIL illegal_dir got %b exp 1", dir); errors++; end
    for (int j = 1; j <= 300; j++) begin
      cur_g = (cur_g == 4'b0011) ? 4'b0000 : 4'b0011;
      apply(cur_g);
      if (j == 253) begin
        checks++; if (err_cnt !== 8'd254) begin $display("FAIL err_cnt_254 got %0d exp 254", err_cnt); errors++; end
      end
      if (j == 254) begin
        checks++; if (err_cnt !== 8'd255) begin $display("FAIL err_cnt_255 got %0d exp 255", err_cnt); errors++; end
      end
    end
    checks++; if (err_cnt !== 8'd255 || step_err !== 1'b1) begin
      $display("FAIL err_cnt_saturate err_cnt=%0d step_err=%b exp 255 and 1", err_cnt, step_err); errors++;
    end
  endtask

  task automatic test_clear;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk); #1;
    checks++; if (step_err !== 1'b0 || err_cnt !== 8'd0) begin
      $display("FAIL clr_alone step_err=%b err_cnt=%0d exp 0 and 0", step_err, err_cnt); errors++;
    end
    @(negedge clk);
    clr_err = 1'b0;
    // Prime the counter so the collision result is distinguishable from a clear.
    cur_g = (cur_g == 4'b0011) ? 4'b0000 : 4'b0011;
    apply(cur_g);
    cur_g = (cur_g == 4'b0011) ? 4'b0000 : 4'b0011;
    apply(cur_g);
    checks++; if (err_cnt !== 8'd2) begin $display("FAIL clr_prime got %0d exp 2", err_cnt); errors++; end
    cur_g = (cur_g == 4'b0011) ? 4'b0000 : 4'b0011;
    @(negedge clk);
    g = cur_g;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk); #1;
    checks++; if (step_err !== 1'b1 || err_cnt !== 8'd1 || b_valid !== 1'b1) begin
      $display("FAIL clr_collision step_err=%b err_cnt=%0d b_valid=%b exp 1,1,1", step_err, err_cnt, b_valid); errors++;
    end
    checks++; if (b !== ((cur_g == 4'b0011) ? 4'd2 : 4'd0)) begin
      $display("FAIL clr_collision_b got %0d", b); errors++;
    end
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_midrun_reset;
    do_reset(4'b1110);
    apply(4'b1111);
    apply(4'b1101);
    checks++; if (b !== 4'd9 || dir !== 1'b0 || step_err !== 1'b0) begin
      $display("FAIL pre_reset b=%0d dir=%b step_err=%b exp 9,0,0", b, dir, step_err); errors++;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (b !== 4'd0 || b_valid !== 1'b0 || dir !== 1'b1 || step_err !== 1'b0 || err_cnt !== 8'd0) begin
      $display("FAIL async_reset b=%0d b_valid=%b dir=%b step_err=%b err_cnt=%0d exp 0,0,1,0,0",
               b, b_valid, dir, step_err, err_cnt); errors++;
    end
    g = 4'b0010;
    #5;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (b !== 4'd0 || b_valid !== 1'b0) begin
      $display("FAIL refill b=%0d b_valid=%b exp 0,0", b, b_valid); errors++;
    end
    @(posedge clk); #1;
    checks++; if (b !== 4'd3 || b_valid !== 1'b1 || step_err !== 1'b0 || err_cnt !== 8'd0) begin
      $display("FAIL reload b=%0d b_valid=%b step_err=%b err_cnt=%0d exp 3,1,0,0", b, b_valid, step_err, err_cnt); errors++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    g = 4'b0000;
    clr_err = 1'b0;
    cur_g = 4'b0000;
    test_reset();
    test_up_sweep();
    test_down_wrap();
    test_illegal_jump();
    test_clear();
    test_midrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
